game_over_ctrl: RTL

- Terminating end of the game-activity path: the start latch raises `active`; this block decides when the game ends.
- Tracks remaining lives and a no-input inactivity timeout.
- Asserts a level `over` plus a one-cycle `over_pulse` for the display/score logic.
- Returns to idle on an explicit `restart`.

---
 rtl/game_pkg.sv | 21 ++
 rtl/idle_timer.sv | 30 +++
 rtl/game_over_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared game-path types: FSM state encoding, life-counter width and saturating helpers.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } game_state_t;

  localparam int LIVES_W = 4;

  function automatic logic [LIVES_W-1:0] sat_inc(input logic [LIVES_W-1:0] value,
                                                 input logic [LIVES_W-1:0] cap);
    return (value >= cap) ? cap : value + LIVES_W'(1);
  endfunction

  function automatic logic [LIVES_W-1:0] sat_dec(input logic [LIVES_W-1:0] value);
    return (value == '0) ? '0 : value - LIVES_W'(1);
  endfunction

endpackage

// File: rtl/idle_timer.sv
// No-input inactivity counter: counts while run=1, flags the last cycle of the timeout window.
module idle_timer #(
  parameter int IDLE_TIMEOUT = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(IDLE_TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = run && (count == LAST);

endmodule

// File: rtl/game_over_ctrl.sv
// Game-end controller: lives, inactivity timeout, registered over/over_pulse/playing/lives_left.
// Optional bonus-life streak logic is enabled by defining GAME_OVER_BONUS_EN.
module game_over_ctrl
  import game_pkg::*;
#(
  parameter int LIVES        = 3,
  parameter int IDLE_TIMEOUT = 1000,
  parameter int BONUS_HITS   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               active,
  input  logic               hit,
  input  logic               miss,
  input  logic               restart,
  output logic               over,
  output logic               over_pulse,
  output logic [LIVES_W-1:0] lives_left,
  output logic               playing
);

  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);

  if (LIVES < 1 || LIVES > 15) begin : g_bad_lives
    $error("game_over_ctrl: LIVES must be 1..15");
  end
  if (IDLE_TIMEOUT < 2) begin : g_bad_timeout
    $error("game_over_ctrl: IDLE_TIMEOUT must be >= 2");
  end
  if (BONUS_HITS < 1) begin : g_bad_bonus
    $error("game_over_ctrl: BONUS_HITS must be >= 1");
  end

  game_state_t        state, state_next;
  logic [LIVES_W-1:0] lives_next;
  logic               timer_clear, timer_run, expired;

`ifdef GAME_OVER_BONUS_EN
  localparam int STREAK_W = $clog2(BONUS_HITS + 1);
  localparam logic [STREAK_W-1:0] STREAK_LAST = STREAK_W'(BONUS_HITS - 1);
  logic [STREAK_W-1:0] streak, streak_next;
`endif

  idle_timer #(
    .IDLE_TIMEOUT(IDLE_TIMEOUT)
  ) u_idle_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .run    (timer_run),
    .expired(expired)
  );

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_next  = state;
    lives_next  = lives_left;
    timer_clear = 1'b1;
    timer_run   = 1'b0;
`ifdef GAME_OVER_BONUS_EN
    streak_next = '0;
`endif
    unique case (state)
      IDLE: begin
        lives_next = LIVES_INIT;
        if (active) state_next = PLAY;
      end
      PLAY: begin
        timer_run   = 1'b1;
        timer_clear = 1'b0;
        if (!active) begin
          state_next  = IDLE;
          lives_next  = LIVES_INIT;
          timer_clear = 1'b1;
        end else if (miss) begin
          // miss outranks a simultaneous hit, which is simply dropped
          timer_clear = 1'b1;
          if (lives_left <= LIVES_W'(1)) begin
            state_next = OVER;
            lives_next = '0;
          end else begin
            lives_next = sat_dec(lives_left);
          end
        end else if (hit) begin
          timer_clear = 1'b1;
`ifdef GAME_OVER_BONUS_EN
          if (streak == STREAK_LAST) begin
            lives_next = sat_inc(lives_left, LIVES_INIT);
          end else begin
            streak_next = streak + STREAK_W'(1);
          end
`endif
        end else if (expired) begin
          state_next  = OVER;
          timer_clear = 1'b1;
        end else begin
`ifdef GAME_OVER_BONUS_EN
          streak_next = streak;
`endif
        end
      end
      OVER: begin
        if (restart) begin
          state_next = IDLE;
          lives_next = LIVES_INIT;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are true registers, not state decodes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      lives_left <= LIVES_INIT;
      over       <= 1'b0;
      over_pulse <= 1'b0;
      playing    <= 1'b0;
    end else begin
      state      <= state_next;
      lives_left <= lives_next;
      over       <= (state_next == OVER);
      over_pulse <= (state_next == OVER) && (state != OVER);
      playing    <= (state_next == PLAY);
    end
  end

`ifdef GAME_OVER_BONUS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) streak <= '0;
    else        streak <= streak_next;
  end
`endif

endmodule
